// File: rtl/nes_dma_pkg.sv
// Shared definitions for the NES sprite DMA engine: FSM state encoding and
// fixed transfer constants.
package nes_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [2:0]  OAMDATA_REG = 3'd4;
    localparam int unsigned DMA_LEN     = 256;

    // Byte index of the final transfer; the page never carries.
    localparam logic [7:0]  LAST_IDX    = 8'(DMA_LEN - 1);

endpackage : nes_dma_pkg

// File: rtl/oam_dma.sv
// Sprite DMA ($4014): stalls the CPU and copies one 256-byte CPU page into
// OAM through PPU register 4, alternating one read and one write cycle.
module oam_dma
    import nes_dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    input  logic        odd_cycle,
    output logic        cpu_rdy,
    output logic        dma_busy,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    input  logic [7:0]  mem_data_in,
    output logic        ppu_reg_cs,
    output logic        ppu_reg_WE,
    output logic [2:0]  ppu_reg_addr,
    output logic [7:0]  ppu_data_out
);

    dma_state_t state, state_n;
    logic [7:0] page_q;
    logic       odd_q;
    logic [7:0] idx_q;

    logic       accept;
    logic       advance;

    // Starts are only honoured from IDLE, so a stray $4014 write mid-transfer
    // leaves the latched page and parity untouched.
    assign accept  = (state == IDLE) && dma_start;
    assign advance = (state == WRITE) && (idx_q != LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            page_q <= '0;
            odd_q  <= 1'b0;
            idx_q  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                page_q <= dma_page;
                odd_q  <= odd_cycle;
                idx_q  <= '0;
            end else if (advance) begin
                idx_q <= idx_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (dma_start) state_n = HALT;
            HALT:  state_n = odd_q ? ALIGN : READ;
            ALIGN: state_n = READ;
            READ:  state_n = WRITE;
            WRITE: state_n = (idx_q == LAST_IDX) ? IDLE : READ;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode registered state only; the data path is the single
    // combinational pass-through, gated so idle cycles drive zero.
    always_comb begin
        cpu_rdy      = 1'b1;
        dma_busy     = 1'b0;
        mem_addr     = '0;
        mem_re       = 1'b0;
        ppu_reg_cs   = 1'b0;
        ppu_reg_WE   = 1'b0;
        ppu_reg_addr = '0;
        ppu_data_out = '0;
        if (state != IDLE) begin
            cpu_rdy  = 1'b0;
            dma_busy = 1'b1;
        end
        if (state == READ) begin
            mem_addr = {page_q, idx_q};
            mem_re   = 1'b1;
        end
        if (state == WRITE) begin
            ppu_reg_cs   = 1'b1;
            ppu_reg_WE   = 1'b1;
            ppu_reg_addr = OAMDATA_REG;
            ppu_data_out = mem_data_in;
        end
    end

endmodule : oam_dma

// File: tb/tb_oam_dma.sv
// Randomised self-checking bench for oam_dma: a cycle-schedule reference model
// plus per-transfer totals and a few literal pins.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dma_start = 1'b0;
    logic [7:0]  dma_page = 8'h00;
    logic        odd_cycle = 1'b0;
    logic        cpu_rdy;
    logic        dma_busy;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_data_in = 8'h00;
    logic        ppu_reg_cs;
    logic        ppu_reg_WE;
    logic [2:0]  ppu_reg_addr;
    logic [7:0]  ppu_data_out;

    oam_dma dut (
        .clk          (clk),
        .reset        (reset),
        .dma_start    (dma_start),
        .dma_page     (dma_page),
        .odd_cycle    (odd_cycle),
        .cpu_rdy      (cpu_rdy),
        .dma_busy     (dma_busy),
        .mem_addr     (mem_addr),
        .mem_re       (mem_re),
        .mem_data_in  (mem_data_in),
        .ppu_reg_cs   (ppu_reg_cs),
        .ppu_reg_WE   (ppu_reg_WE),
        .ppu_reg_addr (ppu_reg_addr),
        .ppu_data_out (ppu_data_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    // CPU memory: one-cycle registered read, garbage when not reading.
    logic [7:0] mem [0:65535];
    always @(posedge clk) mem_data_in <= mem_re ? mem[mem_addr] : 8'($urandom);

    // Reference model: a transfer is a timeline of 513+odd busy cycles; cycle k
    // (k=0 is the cycle after the accepted edge) reads byte (k-1-odd)/2 when
    // k-1-odd is even and writes that byte when it is odd.
    bit         m_busy = 1'b0;
    int         m_k = 0;
    logic [7:0] m_page = 8'h00;
    bit         m_odd = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (dma_start) begin
                m_busy = 1'b1;
                m_k    = 0;
                m_page = dma_page;
                m_odd  = odd_cycle;
            end
        end else begin
            m_k++;
            if (m_k == 513 + int'(m_odd)) m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        int j;
        bit rd;
        bit wr;
        logic [15:0] a;
        if (!reset) begin
            j  = m_k - 1 - int'(m_odd);
            rd = m_busy && (j >= 0) && (j % 2 == 0);
            wr = m_busy && (j >= 0) && (j % 2 == 1);
            a  = {m_page, 8'(j / 2)};
            chk("cpu_rdy",      cpu_rdy,      !m_busy);
            chk("dma_busy",     dma_busy,     m_busy);
            chk("mem_re",       mem_re,       rd);
            chk("mem_addr",     mem_addr,     rd ? a : 16'h0000);
            chk("ppu_reg_cs",   ppu_reg_cs,   wr);
            chk("ppu_reg_WE",   ppu_reg_WE,   wr);
            chk("ppu_reg_addr", ppu_reg_addr, wr ? 3'd4 : 3'd0);
            chk("ppu_data_out", ppu_data_out, wr ? mem[a] : 8'h00);
        end
    end

    int          t_len, t_reads, t_writes, t_first_rd, t_badpage;
    logic [15:0] t_first_addr, t_last_addr;
    logic [7:0]  t_wdata [0:255];

    task automatic check_reset_values(input string tag);
        chk({tag, "_cpu_rdy"},  cpu_rdy,      1'b1);
        chk({tag, "_busy"},     dma_busy,     1'b0);
        chk({tag, "_mem_re"},   mem_re,       1'b0);
        chk({tag, "_mem_addr"}, mem_addr,     16'h0000);
        chk({tag, "_cs"},       ppu_reg_cs,   1'b0);
        chk({tag, "_we"},       ppu_reg_WE,   1'b0);
        chk({tag, "_reg"},      ppu_reg_addr, 3'd0);
        chk({tag, "_data"},     ppu_data_out, 8'h00);
    endtask

    // Starts a transfer and follows it to its first idle cycle; returns with
    // the sim at that idle cycle's falling edge.
    task automatic transfer(input logic [7:0] pg, input bit odd, input bit inject);
        int bad_bytes;
        #1;
        dma_page  = pg;
        odd_cycle = odd;
        dma_start = 1'b1;
        @(posedge clk);
        #1;
        dma_start = 1'b0;
        dma_page  = 8'($urandom);
        odd_cycle = 1'($urandom);
        chk("rdy_low_after_start", cpu_rdy, 1'b0);
        t_len = 0; t_reads = 0; t_writes = 0; t_first_rd = -1; t_badpage = 0;
        t_first_addr = '0; t_last_addr = '0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (cpu_rdy) break;
            if (mem_re) begin
                if (t_first_rd < 0) begin
                    t_first_rd   = i;
                    t_first_addr = mem_addr;
                end
                t_last_addr = mem_addr;
                t_reads++;
                if (mem_addr[15:8] != pg) t_badpage++;
            end
            if (ppu_reg_cs && ppu_reg_WE) begin
                if (t_writes < 256) t_wdata[t_writes] = ppu_data_out;
                t_writes++;
            end
            t_len++;
            if (inject && i == 100) begin
                #1;
                dma_start = 1'b1;
                dma_page  = 8'h07;
                odd_cycle = ~odd;
            end else if (dma_start) begin
                #1;
                dma_start = 1'b0;
            end
        end
        chk("busy_length",  t_len,        513 + int'(odd));
        chk("read_count",   t_reads,      256);
        chk("write_count",  t_writes,     256);
        chk("first_read",   t_first_rd,   1 + int'(odd));
        chk("first_addr",   t_first_addr, {pg, 8'h00});
        chk("last_addr",    t_last_addr,  {pg, 8'hFF});
        chk("foreign_page", t_badpage,    0);
        bad_bytes = 0;
        for (int n = 0; n < 256; n++)
            if (t_wdata[n] !== mem[{pg, 8'(n)}]) bad_bytes++;
        chk("write_order", bad_bytes, 0);
    endtask

    initial begin
        int found;
        logic [15:0] last_rd;

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int n = 0; n < 256; n++) mem[16'h0200 + n] = 8'(n) ^ 8'hA5;

        #2;
        check_reset_values("in_reset");
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        check_reset_values("after_reset");
        repeat (2) @(negedge clk);

        // Even start from page $02, with literal pins on the data pattern.
        transfer(8'h02, 1'b0, 1'b0);
        chk("pin_len_even", t_len,        513);
        chk("pin_w0",       t_wdata[0],   8'hA5);
        chk("pin_w3",       t_wdata[3],   8'hA6);
        chk("pin_w255",     t_wdata[255], 8'h5A);
        repeat (3) @(negedge clk);

        // Odd start: one extra alignment cycle.
        transfer(8'h02, 1'b1, 1'b0);
        chk("pin_len_odd",   t_len,      514);
        chk("pin_first_odd", t_first_rd, 2);
        repeat (2) @(negedge clk);

        // Page $FF: must end at $FFFF without wrapping.
        transfer(8'hFF, 1'b0, 1'b0);
        chk("pin_last_ffff", t_last_addr, 16'hFFFF);
        repeat (2) @(negedge clk);

        // Second start at cycle 100 must be ignored.
        transfer(8'h02, 1'b0, 1'b1);
        repeat (2) @(negedge clk);

        // Back-to-back: restart in the very first idle cycle.
        transfer(8'h11, 1'b1, 1'b0);
        chk("b2b_idle_cycle", cpu_rdy, 1'b1);
        transfer(8'h12, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset during the write of byte 40, then a fresh full transfer.
        #1;
        dma_page  = 8'h40;
        odd_cycle = 1'b0;
        dma_start = 1'b1;
        @(posedge clk);
        #1 dma_start = 1'b0;
        found = 0;
        last_rd = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_re) last_rd = mem_addr;
            if (ppu_reg_cs && last_rd == 16'h4028) begin
                found = 1;
                break;
            end
        end
        chk("reset_point_found", found, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_values("async_reset");
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values("post_abort");
        transfer(8'h03, 1'b0, 1'b0);
        chk("pin_restart_first", t_first_addr, 16'h0300);

        // Randomised transfers.
        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            transfer(8'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_oam_dma

// File: doc/oam_dma.md
# oam_dma

Sprite DMA engine for the NES core: on a CPU write to $4014 it stalls the CPU and copies one 256-byte page of CPU address space into sprite memory through the PPU register port (OAMDATA, register 4). It sits between the CPU memory bus and the PPU register interface, acting as a second master on that interface. While it runs it owns both buses, and the CPU is held off through its ready line.

## Interface
Parameters:
- OAMDATA_REG, 3'd4: PPU register index targeted by every DMA write.
- DMA_LEN, 256: bytes per transfer, fixed at one page.

Ports:
- clk  in  1  system clock; one clock, every state advances on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- dma_start  in  1  one-cycle strobe: CPU write to $4014.
- dma_page  in  8  source page (CPU data on the $4014 write); sampled with dma_start.
- odd_cycle  in  1  high when the CPU cycle carrying dma_start is odd; sampled with dma_start.
- cpu_rdy  out  1  low stalls the CPU; high when idle.
- dma_busy  out  1  high from the first cycle after an accepted start through the last write.
- mem_addr  out  16  CPU-bus read address.
- mem_re  out  1  CPU-bus read strobe.
- mem_data_in  in  8  read data, valid the cycle after mem_re.
- ppu_reg_cs  out  1  PPU register chip select.
- ppu_reg_WE  out  1  PPU register write enable.
- ppu_reg_addr  out  3  PPU register index.
- ppu_data_out  out  8  byte written to the PPU register.

## Operation
- States:
  - IDLE -> HALT -> (ALIGN if the latched odd flag is set) -> READ <-> WRITE -> IDLE.
- IDLE:
  - A dma_start pulse latches dma_page, odd_cycle and clears the 8-bit byte counter idx.
  - The next state is HALT.
- HALT: one dummy cycle that lets the CPU finish its write. No bus activity.
- ALIGN: one dummy cycle, entered only when odd_cycle was latched high. No bus activity.
- READ:
  - mem_addr = {page, idx}, mem_re = 1.
  - The next state is WRITE.
- WRITE:
  - ppu_reg_cs = 1, ppu_reg_WE = 1, ppu_reg_addr = OAMDATA_REG.
  - ppu_data_out = mem_data_in, a combinational pass-through qualified by the state.
  - When idx == 8'hFF the next state is IDLE. Otherwise idx increments and the next state is READ.
- Address handling:
  - idx is 8 bits. The page is never incremented.
  - Addresses run $pp00..$ppFF exactly, with no carry into the page.
- Dummy-cycle and idle outputs:
  - mem_re, ppu_reg_cs and ppu_reg_WE are 0 outside READ and WRITE respectively.
  - mem_addr and ppu_data_out are 0 when not driven.
- dma_start while dma_busy is high is ignored. The latched page and flag are unchanged.
- The OAMADDR auto-increment is the PPU register block's responsibility. This block always writes register 4.

## Timing
- Reset values: cpu_rdy=1, dma_busy=0, mem_re=0, mem_addr=0, ppu_reg_cs=0, ppu_reg_WE=0, ppu_reg_addr=0, ppu_data_out=0, state IDLE, idx=0.
- Reset asserted mid-transfer:
  - The block returns to IDLE immediately (asynchronously) and releases cpu_rdy.
  - A partial transfer is abandoned and not resumed.
- Start timing:
  - dma_start is sampled at edge E0.
  - From E0: cpu_rdy=0 and dma_busy=1.
- Cycle counts:
  - Busy length is 1 + odd + 512 cycles (513 or 514).
  - The first READ is at cycle 1 + odd after E0.
  - READ of byte n is followed by WRITE of byte n on the next cycle. There is no pipelining overlap.
- End of transfer:
  - After the WRITE of byte 255, the next edge returns to IDLE.
  - cpu_rdy=1 and dma_busy=0 in that same cycle.
- Back-to-back:
  - A dma_start in the first IDLE cycle after completion is accepted.
- All outputs are registered-state decodes. No output depends combinationally on dma_start.
  - Exception: ppu_data_out follows mem_data_in.

## Structure
- Shared package nes_dma_pkg holds:
  - the state enum dma_state_t (IDLE, HALT, ALIGN, READ, WRITE);
  - OAMDATA_REG;
  - DMA_LEN.
- Single module. The FSM, idx counter and page/odd latches are small enough that no sub-module is warranted.

## Test plan
- Even start:
  - Stimulus: dma_start with page 8'h02, odd_cycle=0; memory $0200+n = n^8'hA5.
  - Response: 256 writes to register 4 with data n^8'hA5 in order; cpu_rdy low for exactly 513 cycles.
- Odd start:
  - Stimulus: same as even start with odd_cycle=1.
  - Response: first mem_re at cycle 2 after E0; cpu_rdy low for 514 cycles.
- Page boundary:
  - Stimulus: page 8'hFF.
  - Response: last address is $FFFF; no access to $0000 and no 257th access.
- Ignored start:
  - Stimulus: a second dma_start with page 8'h07 at cycle 100.
  - Response: ignored; all addresses stay in $02xx; total length is unchanged.
- Reset mid-transfer:
  - Stimulus: reset pulse at byte 40.
  - Response: all outputs return to reset values without waiting for a clock edge; a new start with page 8'h03 then completes all 256 bytes from $0300.
- Back-to-back:
  - Stimulus: dma_start in the first IDLE cycle after completion.
  - Response: accepted; cpu_rdy is high for exactly that one cycle.
